// File: rtl/fp_div_arbiter_if.sv
// Requester, divider and response signals of the shared FP divider arbiter.
// slave = arbiter view, master = surrounding requesters plus divider.
interface fp_div_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int W       = 32,
   parameter int ID_W    = 2
);
   logic                 issue_en;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*W-1:0] req_a;
   logic [NUM_REQ*W-1:0] req_b;
   logic [W-1:0]         div_a;
   logic [W-1:0]         div_b;
   logic                 div_ab_valid;
   logic [W-1:0]         div_z;
   logic                 div_z_valid;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic [W-1:0]         rsp_z;
   logic                 tag_err;

   modport slave (
      input  issue_en, req_valid, req_a, req_b, div_z, div_z_valid,
      output req_ready, div_a, div_b, div_ab_valid, rsp_valid, rsp_id, rsp_z, tag_err
   );

   modport master (
      output issue_en, req_valid, req_a, req_b, div_z, div_z_valid,
      input  req_ready, div_a, div_b, div_ab_valid, rsp_valid, rsp_id, rsp_z, tag_err
   );
endinterface

// File: rtl/fp_div_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined FP divider among NUM_REQ requesters.
// Operands registered 1 cycle after grant; response DIV_STAGES+2 cycles after handshake; no response back-pressure.
module fp_div_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int sig_width  = 23,
   parameter int exp_width  = 8,
   parameter int DIV_STAGES = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_div_arbiter_if.slave bus
);
   localparam int W    = sig_width + exp_width + 1;
   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]                  idx;
   logic                             gnt_vld;
   logic [ID_W-1:0]                  gnt_id;
   logic [NUM_REQ-1:0]               grant;
   logic [W-1:0]                     sel_a, sel_b;
   logic [W-1:0]                     div_a_q, div_b_q;
   logic                             div_vld_q;
   logic [DIV_STAGES:0]              tag_vld_q;
   logic [DIV_STAGES:0][ID_W-1:0]    tag_id_q;
   logic [NUM_REQ-1:0]               rsp_valid_q;
   logic [ID_W-1:0]                  rsp_id_q;
   logic [W-1:0]                     rsp_z_q;
   logic                             tag_err_q;

   // Grant is gated by rst_n so nothing is offered while the block is held in reset.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (rst_n && bus.issue_en && !gnt_vld && bus.req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
      grant    = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   assign sel_a = bus.req_a[int'(gnt_id)*W +: W];
   assign sel_b = bus.req_b[int'(gnt_id)*W +: W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         div_vld_q   <= 1'b0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         rsp_z_q     <= '0;
         tag_err_q   <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         div_vld_q <= gnt_vld;
         if (gnt_vld) begin
            div_a_q <= sel_a;
            div_b_q <= sel_b;
         end
         // Tail of the tag pipe lines up with the divider's div_z_valid.
         tag_vld_q <= {tag_vld_q[DIV_STAGES-1:0], gnt_vld};
         tag_id_q  <= {tag_id_q[DIV_STAGES-1:0], gnt_id};
         if (tag_vld_q[DIV_STAGES]) begin
            rsp_valid_q <= NUM_REQ'(1) << tag_id_q[DIV_STAGES];
            rsp_id_q    <= tag_id_q[DIV_STAGES];
            rsp_z_q     <= bus.div_z;
         end else begin
            rsp_valid_q <= '0;
         end
         if (bus.div_z_valid != tag_vld_q[DIV_STAGES]) begin
            tag_err_q <= 1'b1;
         end
      end
   end

   assign bus.req_ready    = grant;
   assign bus.div_a        = div_a_q;
   assign bus.div_b        = div_b_q;
   assign bus.div_ab_valid = div_vld_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_z        = rsp_z_q;
   assign bus.tag_err      = tag_err_q;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a behavioural 5-stage divider on the divider side.
// Quotients come from a hand-computed table of exact IEEE-754 single results.
module tb_fp_div_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int W          = 32;
   localparam int ID_W       = 2;
   localparam int DIV_STAGES = 5;
   localparam int RSP_LAT    = DIV_STAGES + 2;

   logic clk = 1'b0;
   logic rst_n;
   logic force_zv;
   always #5 clk = ~clk;

   fp_div_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W), .ID_W(ID_W)) bus ();

   fp_div_arbiter #(
      .NUM_REQ(NUM_REQ), .sig_width(23), .exp_width(8), .DIV_STAGES(DIV_STAGES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Operand table: 1/2, 4/2, 6/2, 10/2 and their exact quotients.
   logic [W-1:0] a_tab [NUM_REQ] = '{32'h3F800000, 32'h40800000, 32'h40C00000, 32'h41200000};
   logic [W-1:0] q_tab [NUM_REQ] = '{32'h3F000000, 32'h40000000, 32'h40400000, 32'h40A00000};
   logic [3:0]   t2_gnt [8]      = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                     4'b0010, 4'b0100, 4'b1000, 4'b0001};

   function automatic logic [W-1:0] fake_div(input logic [W-1:0] a, input logic [W-1:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h3F000000;
         {32'h40800000, 32'h40000000}: return 32'h40000000;
         {32'h40C00000, 32'h40000000}: return 32'h40400000;
         {32'h41200000, 32'h40000000}: return 32'h40A00000;
         {32'h40C00000, 32'h40400000}: return 32'h40000000;
         default:                      return 32'hDEADBEEF;
      endcase
   endfunction

   logic [DIV_STAGES-1:0]         dm_vld_q;
   logic [DIV_STAGES-1:0][W-1:0]  dm_z_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dm_vld_q <= '0;
         dm_z_q   <= '0;
      end else begin
         dm_vld_q <= {dm_vld_q[DIV_STAGES-2:0], bus.div_ab_valid};
         dm_z_q   <= {dm_z_q[DIV_STAGES-2:0], fake_div(bus.div_a, bus.div_b)};
      end
   end
   assign bus.div_z_valid = dm_vld_q[DIV_STAGES-1] | force_zv;
   assign bus.div_z       = dm_z_q[DIV_STAGES-1];

   int checks   = 0;
   int failures = 0;
   logic         exp_tag_err;
   logic         en_v  [16];
   logic [3:0]   vld_v [16];
   logic [3:0]   gnt_v [16];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int oh2id(input logic [3:0] oh);
      for (int i = 0; i < NUM_REQ; i++) if (oh[i]) return i;
      return 0;
   endfunction

   task automatic setv(input int i, input logic en, input logic [3:0] v, input logic [3:0] g);
      en_v[i]  = en;
      vld_v[i] = v;
      gnt_v[i] = g;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " req_ready"}, W'(bus.req_ready), '0);
      chk({name, " div_ab_valid"}, W'(bus.div_ab_valid), '0);
      chk({name, " div_a"}, bus.div_a, '0);
      chk({name, " div_b"}, bus.div_b, '0);
      chk({name, " rsp_valid"}, W'(bus.rsp_valid), '0);
      chk({name, " rsp_id"}, W'(bus.rsp_id), '0);
      chk({name, " rsp_z"}, bus.rsp_z, '0);
      chk({name, " tag_err"}, W'(bus.tag_err), '0);
   endtask

   // Plays n vector cycles then drains; checks grants, issue regs and responses every cycle.
   task automatic run_seq(input int n, input string name);
      logic [3:0] er;
      logic [3:0] prev;
      for (int c = 0; c <= n + RSP_LAT; c++) begin
         if (c < n) begin
            bus.issue_en  = en_v[c];
            bus.req_valid = vld_v[c];
         end else begin
            bus.issue_en  = 1'b1;
            bus.req_valid = '0;
         end
         #1;
         chk({name, " req_ready"}, W'(bus.req_ready), (c < n) ? W'(gnt_v[c]) : '0);
         er = '0;
         if (c >= RSP_LAT && c - RSP_LAT < n) er = gnt_v[c-RSP_LAT];
         chk({name, " rsp_valid"}, W'(bus.rsp_valid), W'(er));
         if (er != 0) begin
            chk({name, " rsp_id"}, W'(bus.rsp_id), W'(oh2id(er)));
            chk({name, " rsp_z"}, bus.rsp_z, q_tab[oh2id(er)]);
         end
         prev = '0;
         if (c >= 1 && c - 1 < n) prev = gnt_v[c-1];
         chk({name, " div_ab_valid"}, W'(bus.div_ab_valid), W'(prev != 0));
         if (prev != 0) begin
            chk({name, " div_a"}, bus.div_a, a_tab[oh2id(prev)]);
            chk({name, " div_b"}, bus.div_b, 32'h40000000);
         end
         chk({name, " tag_err"}, W'(bus.tag_err), W'(exp_tag_err));
         tick();
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      force_zv      = 1'b0;
      exp_tag_err   = 1'b0;
      bus.issue_en  = 1'b1;
      bus.req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_a[i*W +: W] = a_tab[i];
         bus.req_b[i*W +: W] = 32'h40000000;
      end
      #1;
      chk_all_zero("reset");
      tick();
      bus.req_valid = '0;
      rst_n         = 1'b1;
      tick();

      // Single op from req0: 1.0 / 2.0.
      setv(0, 1'b1, 4'b0001, 4'b0001);
      run_seq(1, "t1");

      // All requesters valid; pointer starts at 1 after the first test.
      for (int k = 0; k < 8; k++) setv(k, 1'b1, 4'b1111, t2_gnt[k]);
      run_seq(8, "t2");

      // Move pointer to 2, then req1+req3 valid: req3 first, then req1.
      setv(0, 1'b1, 4'b0010, 4'b0010);
      setv(1, 1'b1, 4'b1010, 4'b1000);
      setv(2, 1'b1, 4'b1010, 4'b0010);
      setv(3, 1'b1, 4'b1111, 4'b0100);
      run_seq(4, "t3");

      // Two ops in flight, then issue_en low for three cycles.
      setv(0, 1'b1, 4'b1111, 4'b1000);
      setv(1, 1'b1, 4'b1111, 4'b0001);
      setv(2, 1'b0, 4'b1111, 4'b0000);
      setv(3, 1'b0, 4'b1111, 4'b0000);
      setv(4, 1'b0, 4'b1111, 4'b0000);
      run_seq(5, "t4");

      // req2 issues 6.0/3.0, reset arrives three cycles later and drops it.
      bus.req_a[2*W +: W] = 32'h40C00000;
      bus.req_b[2*W +: W] = 32'h40400000;
      bus.issue_en  = 1'b1;
      bus.req_valid = 4'b0100;
      #1;
      chk("t5 req_ready", W'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = '0;
      chk("t5 div_ab_valid", W'(bus.div_ab_valid), 32'h1);
      chk("t5 div_b", bus.div_b, 32'h40400000);
      tick();
      tick();
      rst_n         = 1'b0;
      bus.req_valid = '1;
      #1;
      chk_all_zero("t5 in reset");
      tick();
      tick();
      chk_all_zero("t5 held reset");
      bus.req_valid = '0;
      rst_n         = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t5 no rsp", W'(bus.rsp_valid), '0);
      end
      chk("t5 tag_err", W'(bus.tag_err), '0);
      bus.req_b[2*W +: W] = 32'h40000000;

      // Spurious divider valid with empty tag pipe sets the sticky error.
      force_zv = 1'b1;
      tick();
      force_zv = 1'b0;
      chk("t6 tag_err set", W'(bus.tag_err), 32'h1);
      chk("t6 rsp_valid", W'(bus.rsp_valid), '0);
      exp_tag_err = 1'b1;
      setv(0, 1'b1, 4'b0001, 4'b0001);
      run_seq(1, "t6");
      rst_n = 1'b0;
      #1;
      chk("t6 tag_err reset", W'(bus.tag_err), '0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6 tag_err after reset", W'(bus.tag_err), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
